// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl
//
// Client-side access sequencer for a single-port synchronous RAM with a
// registered read port (one-cycle read latency, write on cen && we).
// Turns a valid/ready request stream into RAM port cycles, returns read data
// with a one-cycle ack pulse, and owns a fill engine that sweeps the whole RAM
// with CLEAR_VALUE after reset (CLEAR_ON_RESET) or when clear_start is pulsed.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req           client request valid
//   req_ready     request accepted this cycle (idle and no clear pending)
//   req_we        1 = write, 0 = read
//   req_addr      request address
//   req_wdata     write data
//   ack           one-cycle completion pulse
//   rdata         read result, valid with ack and held until the next read
//   clear_start   pulse: request a fill sweep
//   busy          fill sweep pending or running
//   ADDR, DATA    RAM address / write data (registered)
//   cen, we       RAM enable / write enable (decoded from state)
//   Q             RAM registered read data

module sram_access_ctrl #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 10,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  clear_start,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ADDR,
  output logic [DATA_WIDTH-1:0] DATA,
  output logic                  cen,
  output logic                  we,
  input  logic [DATA_WIDTH-1:0] Q
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_CAPT,
    ST_RESP,
    ST_CLEAR
  } state_t;

  localparam state_t                RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
  logic [DATA_WIDTH-1:0]   data_q,  data_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    wr_q,    wr_d;
  logic                    pend_q,  pend_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    pend_d  = pend_q;

    // A clear request arriving while a sweep is already running is dropped;
    // the running sweep already covers the whole array.
    if (clear_start && (state_q != ST_CLEAR)) begin
      pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d = ST_CLEAR;
          pend_d  = 1'b0;
          addr_d  = '0;
          data_d  = CLEAR_VALUE;
        end else if (req) begin
          state_d = ST_ACCESS;
          addr_d  = req_addr;
          data_d  = req_wdata;
          wr_d    = req_we;
        end
      end
      ST_ACCESS: begin
        state_d = wr_q ? ST_RESP : ST_CAPT;
      end
      ST_CAPT: begin
        // RAM output register holds the word addressed during ACCESS.
        rdata_d = Q;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // A clear that arrived mid-request starts right after the ack.
        if (pend_q) begin
          state_d = ST_CLEAR;
          pend_d  = 1'b0;
          addr_d  = '0;
          data_d  = CLEAR_VALUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        // Address wraps to 0 on the last word, leaving the port parked at 0.
        addr_d = addr_q + ADDR_ONE;
        if (addr_q == ADDR_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      addr_q  <= '0;
      data_q  <= CLEAR_VALUE;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      pend_q  <= pend_d;
    end
  end

  assign cen       = (state_q == ST_ACCESS) || (state_q == ST_CLEAR);
  assign we        = ((state_q == ST_ACCESS) && wr_q) || (state_q == ST_CLEAR);
  assign ack       = (state_q == ST_RESP);
  assign req_ready = (state_q == ST_IDLE) && !pend_q;
  assign busy      = pend_q || (state_q == ST_CLEAR);
  assign ADDR      = addr_q;
  assign DATA      = data_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Self-checking bench for sram_access_ctrl.
// Instance u_dut_a: ADDR_WIDTH=4, CLEAR_ON_RESET=1, CLEAR_VALUE=0xA5.
// Instance u_dut_b: same widths, CLEAR_ON_RESET=0.
// Each instance drives a small behavioural RAM. The expected memory contents
// and the expected read result are kept in exp_mem / exp_rdata, and every
// request is checked against fixed cycle latencies (write ack at N+2, read ack
// at N+3 after acceptance in cycle N).

module tb_sram_access_ctrl;

  localparam int         DW = 8;
  localparam int         AW = 4;
  localparam int         DEPTH = 16;
  localparam logic [7:0] CV = 8'hA5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;

  logic          req, req_we, clear_start;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, ack, busy, cen, we;
  logic [DW-1:0] rdata, ram_data, ram_q;
  logic [AW-1:0] ram_addr;

  logic          b_req, b_req_we, b_clear_start;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_wdata;
  logic          b_req_ready, b_ack, b_busy, b_cen, b_we;
  logic [DW-1:0] b_rdata, b_ram_data, b_ram_q;
  logic [AW-1:0] b_ram_addr;

  logic [DW-1:0] ram_a   [DEPTH];
  logic [DW-1:0] ram_b   [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] exp_rdata;
  logic [DW-1:0] b_exp2;

  int n_total = 0;
  int n_bad   = 0;
  bit prev_hold = 1'b0;

  sram_access_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)
  ) u_dut_a (
    .clk(clk), .rst(rst),
    .req(req), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .ack(ack), .rdata(rdata),
    .clear_start(clear_start), .busy(busy),
    .ADDR(ram_addr), .DATA(ram_data), .cen(cen), .we(we), .Q(ram_q)
  );

  sram_access_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(CV)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .req(b_req), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .ack(b_ack), .rdata(b_rdata),
    .clear_start(b_clear_start), .busy(b_busy),
    .ADDR(b_ram_addr), .DATA(b_ram_data), .cen(b_cen), .we(b_we), .Q(b_ram_q)
  );

  // Behavioural single-port RAMs with registered read output.
  always @(posedge clk) begin
    if (cen) begin
      if (we) ram_a[ram_addr] <= ram_data;
      else    ram_q <= ram_a[ram_addr];
    end
  end

  always @(posedge clk) begin
    if (b_cen) begin
      if (b_we) ram_b[b_ram_addr] <= b_ram_data;
      else      b_ram_q <= ram_b[b_ram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects the current cycle to be the first sweep cycle (ADDR 0).
  task automatic check_sweep(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      check_eq({tag, "_cen"},  32'(cen), 32'd1);
      check_eq({tag, "_we"},   32'(we), 32'd1);
      check_eq({tag, "_addr"}, 32'(ram_addr), 32'(i));
      check_eq({tag, "_data"}, 32'(ram_data), 32'(CV));
      check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      check_eq({tag, "_rdy"},  32'(req_ready), 32'd0);
      tick();
    end
    check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_eq({tag, "_rdy_end"},  32'(req_ready), 32'd1);
    check_eq({tag, "_cen_end"},  32'(cen), 32'd0);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = CV;
  endtask

  // One request on instance A. hold keeps req high afterwards (back-to-back);
  // clr_capt pulses clear_start during the CAPT cycle of a read.
  task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit hold, input bit clr_capt, input string tag);
    int waitc;
    waitc     = 0;
    req       = 1'b1;
    req_we    = w;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && waitc < 50) begin
      tick();
      waitc++;
    end
    if (!req_ready) begin
      check_eq({tag, "_ready_timeout"}, 32'd0, 32'd1);
      req = 1'b0;
      return;
    end
    if (prev_hold) check_eq({tag, "_b2b_wait"}, 32'(waitc), 32'd0);
    tick();
    if (!hold) req = 1'b0;
    check_eq({tag, "_acc_cen"}, 32'(cen), 32'd1);
    check_eq({tag, "_acc_we"},  32'(we), 32'(w));
    check_eq({tag, "_acc_addr"}, 32'(ram_addr), 32'(a));
    check_eq({tag, "_acc_rdy"}, 32'(req_ready), 32'd0);
    check_eq({tag, "_acc_ack"}, 32'(ack), 32'd0);
    if (w) begin
      check_eq({tag, "_acc_data"}, 32'(ram_data), 32'(d));
      exp_mem[a] = d;
      tick();
      check_eq({tag, "_wack"}, 32'(ack), 32'd1);
    end else begin
      tick();
      check_eq({tag, "_capt_cen"}, 32'(cen), 32'd0);
      check_eq({tag, "_capt_ack"}, 32'(ack), 32'd0);
      if (clr_capt) clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      exp_rdata = exp_mem[a];
      check_eq({tag, "_rack"}, 32'(ack), 32'd1);
      check_eq({tag, "_rdata"}, 32'(rdata), 32'(exp_rdata));
      if (clr_capt) check_eq({tag, "_busy_resp"}, 32'(busy), 32'd1);
    end
    tick();
    check_eq({tag, "_ack_drop"}, 32'(ack), 32'd0);
    check_eq({tag, "_rdata_hold"}, 32'(rdata), 32'(exp_rdata));
    check_eq({tag, "_rdy_after"}, 32'(req_ready), 32'(!clr_capt));
    prev_hold = hold;
  endtask

  // Instance B: first read after reset, no sweep in front of it.
  initial begin
    b_req = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_clear_start = 1'b0;
    @(negedge rst);
    b_req      = 1'b1;
    b_req_addr = 4'h2;
    tick();
    b_req = 1'b0;
    check_eq("b_acc_cen", 32'(b_cen), 32'd1);
    check_eq("b_acc_we", 32'(b_we), 32'd0);
    check_eq("b_acc_addr", 32'(b_ram_addr), 32'd2);
    tick();
    check_eq("b_capt_ack", 32'(b_ack), 32'd0);
    tick();
    check_eq("b_ack", 32'(b_ack), 32'd1);
    check_eq("b_rdata", 32'(b_rdata), 32'(b_exp2));
    check_eq("b_busy", 32'(b_busy), 32'd0);
    tick();
    check_eq("b_ack_drop", 32'(b_ack), 32'd0);
  end

  initial begin
    bit          h;
    logic        rw;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    rst = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; clear_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ram_a[i] = 8'($urandom);
      if (ram_a[i] == CV) ram_a[i] = 8'h00;
      ram_b[i] = 8'($urandom);
      exp_mem[i] = ram_a[i];
    end
    b_exp2    = ram_b[2];
    exp_rdata = '0;

    // Reset held for three cycles.
    repeat (3) begin
      tick();
      check_eq("rst_cen", 32'(cen), 32'd1);
      check_eq("rst_we", 32'(we), 32'd1);
      check_eq("rst_addr", 32'(ram_addr), 32'd0);
      check_eq("rst_data", 32'(ram_data), 32'(CV));
      check_eq("rst_busy", 32'(busy), 32'd1);
      check_eq("rst_rdy", 32'(req_ready), 32'd0);
      check_eq("rst_ack", 32'(ack), 32'd0);
      check_eq("rst_rdata", 32'(rdata), 32'd0);
      check_eq("b_rst_cen", 32'(b_cen), 32'd0);
      check_eq("b_rst_busy", 32'(b_busy), 32'd0);
      check_eq("b_rst_rdy", 32'(b_req_ready), 32'd1);
    end
    rst = 1'b0;
    check_sweep("init_sweep");

    for (int k = 0; k < 4; k++) do_req(1'b0, 4'($urandom), 8'h00, 1'b0, 1'b0, "rd_fill");

    do_req(1'b1, 4'h3, 8'h5A, 1'b0, 1'b0, "wr3");
    do_req(1'b0, 4'h3, 8'h00, 1'b0, 1'b0, "rd3");

    // Back-to-back with req held high; includes read-after-write at 0xF.
    do_req(1'b1, 4'h0, 8'h77, 1'b1, 1'b0, "b2b_w0");
    do_req(1'b1, 4'hF, 8'h3C, 1'b1, 1'b0, "b2b_wf");
    do_req(1'b0, 4'h0, 8'h00, 1'b1, 1'b0, "b2b_r0");
    do_req(1'b0, 4'hF, 8'h00, 1'b1, 1'b0, "b2b_rf");
    do_req(1'b1, 4'hF, 8'hC3, 1'b1, 1'b0, "b2b_wf2");
    do_req(1'b0, 4'hF, 8'h00, 1'b0, 1'b0, "b2b_rf2");

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      rw = 1'($urandom);
      ra = 4'($urandom);
      rd = 8'($urandom);
      h  = (k == 39) ? 1'b0 : 1'($urandom);
      do_req(rw, ra, rd, h, 1'b0, "rnd");
      if (!h) repeat ($urandom_range(0, 2)) tick();
    end
    req = 1'b0;

    // Clear requested during the CAPT cycle of a read.
    do_req(1'b1, 4'h6, 8'h42, 1'b0, 1'b0, "wr6");
    do_req(1'b0, 4'h6, 8'h00, 1'b0, 1'b1, "rd6_clr");
    check_sweep("capt_sweep");
    do_req(1'b0, 4'h6, 8'h00, 1'b0, 1'b0, "rd6_after");

    // Reset at sweep address 7.
    do_req(1'b1, 4'h9, 8'h11, 1'b0, 1'b0, "wr9");
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    check_eq("pend_busy", 32'(busy), 32'd1);
    check_eq("pend_rdy", 32'(req_ready), 32'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      check_eq("part_addr", 32'(ram_addr), 32'(i));
      if (i < 7) tick();
    end
    rst = 1'b1;
    tick();
    check_eq("midrst_addr", 32'(ram_addr), 32'd0);
    check_eq("midrst_cen", 32'(cen), 32'd1);
    check_eq("midrst_busy", 32'(busy), 32'd1);
    check_eq("midrst_rdata", 32'(rdata), 32'd0);
    tick();
    check_eq("midrst_addr2", 32'(ram_addr), 32'd0);
    rst = 1'b0;
    exp_rdata = '0;
    prev_hold = 1'b0;
    check_sweep("rst_sweep");
    do_req(1'b0, 4'h9, 8'h00, 1'b0, 1'b0, "rd9_after");

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
